// File: rtl/ctrl_pkg.sv
// Shared control definitions for the RV32IM multi-cycle sequencer and its datapath:
// state encoding, opcodes, ALU op codes, trap causes and the latched control bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_MULDIV = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IFETCH  = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] alu_op;
        logic       alu_src;
    } ctrl_bundle_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode/funct7 decode into the control bundle plus an illegal flag.
// RV32M_EN makes funct7=0000001 on the R opcode a legal multiply/divide.
module main_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode_i,
    input  logic [6:0]   funct7_i,
    output ctrl_bundle_t bundle_o,
`ifdef RV32M_EN
    output logic         muldiv_o,
`endif
    output logic         illegal_o
);

    always_comb begin
        bundle_o  = '0;
        illegal_o = 1'b0;
`ifdef RV32M_EN
        muldiv_o  = 1'b0;
`endif
        case (opcode_i)
            OP_R: begin
                bundle_o.reg_write = 1'b1;
                bundle_o.alu_op    = ALU_FUNCT;
                if (funct7_i == F7_MULDIV) begin
`ifdef RV32M_EN
                    muldiv_o  = 1'b1;
`else
                    illegal_o = 1'b1;
`endif
                end
            end
            OP_I: begin
                bundle_o.reg_write = 1'b1;
                bundle_o.alu_op    = ALU_FUNCT;
                bundle_o.alu_src   = 1'b1;
            end
            OP_LW: begin
                bundle_o.mem_read   = 1'b1;
                bundle_o.mem_to_reg = 1'b1;
                bundle_o.reg_write  = 1'b1;
                bundle_o.alu_op     = ALU_ADD;
                bundle_o.alu_src    = 1'b1;
            end
            OP_SW: begin
                bundle_o.mem_write = 1'b1;
                bundle_o.alu_op    = ALU_ADD;
                bundle_o.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                bundle_o.branch = 1'b1;
                bundle_o.alu_op = ALU_SUB;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32IM sequencer: FETCH/DECODE/EXEC/MEM/MULDIV/WB/TRAP with bus timeouts
// and a retired-instruction counter. RV32M_EN enables the MULDIV state and muldiv_start.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [6:0]           funct7,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 muldiv_done,
    output logic                 imem_req,
    output logic                 ir_load,
    output logic                 pc_write,
    output logic                 branch,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic [1:0]           alu_op,
    output logic                 alu_src,
    output logic                 reg_write,
    output logic                 muldiv_start,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_DECODE = ST_DECODE;
    localparam logic [2:0] S_EXEC   = ST_EXEC;
    localparam logic [2:0] S_MEM    = ST_MEM;
    localparam logic [2:0] S_WB     = ST_WB;
    localparam logic [2:0] S_TRAP   = ST_TRAP;
`ifdef RV32M_EN
    localparam logic [2:0] S_MULDIV = ST_MULDIV;
`endif

    localparam int               TMO_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

    logic [2:0]           state_q, state_d;
    ctrl_bundle_t         bundle_q, bundle_d;
    ctrl_bundle_t         dec_bundle;
    logic                 dec_illegal;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [1:0]           cause_q, cause_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 retire;

`ifdef RV32M_EN
    logic dec_muldiv;
    logic md_busy_q, md_busy_d;
`endif

    main_decoder u_main_decoder (
        .opcode_i  (opcode),
        .funct7_i  (funct7),
        .bundle_o  (dec_bundle),
`ifdef RV32M_EN
        .muldiv_o  (dec_muldiv),
`endif
        .illegal_o (dec_illegal)
    );

    // tmo_d defaults to 0, so any state change clears the timeout count.
    always_comb begin
        state_d  = state_q;
        bundle_d = bundle_q;
        cause_d  = cause_q;
        tmo_d    = '0;
        retire   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_MAX) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IFETCH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DECODE: begin
                bundle_d = dec_bundle;
                if (dec_illegal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
`ifdef RV32M_EN
                end else if (dec_muldiv) begin
                    state_d = S_MULDIV;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bundle_q.mem_read || bundle_q.mem_write) begin
                    state_d = S_MEM;
                end else if (bundle_q.branch) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (bundle_q.mem_read) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DMEM;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
`ifdef RV32M_EN
            S_MULDIV: begin
                if (muldiv_done) state_d = S_WB;
            end
`endif
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign instret_d = retire ? instret_q + 1'b1 : instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            bundle_q  <= '0;
            tmo_q     <= '0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            bundle_q  <= bundle_d;
            tmo_q     <= tmo_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

`ifdef RV32M_EN
    // Set after the first MULDIV cycle so the start strobe is a single pulse.
    assign md_busy_d = (state_q == S_MULDIV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) md_busy_q <= 1'b0;
        else     md_busy_q <= md_busy_d;
    end

    assign muldiv_start = (state_q == S_MULDIV) && !md_busy_q;
`else
    logic unused_muldiv_done;
    assign unused_muldiv_done = muldiv_done;
    assign muldiv_start       = 1'b0;
`endif

    // FETCH strobes are held low while reset is asserted.
    assign imem_req   = !rst && (state_q == S_FETCH);
    assign ir_load    = imem_req && imem_ready;
    assign pc_write   = imem_req && imem_ready;

    assign alu_op     = (state_q == S_EXEC) ? bundle_q.alu_op : 2'b00;
    assign alu_src    = (state_q == S_EXEC) && bundle_q.alu_src;
    assign branch     = (state_q == S_EXEC) && bundle_q.branch;
    assign mem_read   = (state_q == S_MEM)  && bundle_q.mem_read;
    assign mem_write  = (state_q == S_MEM)  && bundle_q.mem_write;
    assign reg_write  = (state_q == S_WB)   && bundle_q.reg_write;
    assign mem_to_reg = (state_q == S_WB)   && bundle_q.mem_to_reg;

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle sequencer for the RV32IM core, placed between the instruction register and the datapath. It decodes each instruction once into a latched control bundle and steps it through FETCH/DECODE/EXEC/MEM/WB. It waits on memory and multiply/divide handshakes, detects illegal opcodes and bus timeouts, and counts retired instructions.

## Interface
- `MEM_TIMEOUT`, default 15: cycles a fetch or data access may wait for ready before a bus error.
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 7: instruction-register bits [6:0].
- `funct7` in 7: instruction-register bits [31:25].
- `imem_ready` in 1: instruction fetch complete this cycle.
- `dmem_ready` in 1: data access complete this cycle.
- `muldiv_done` in 1: multiply/divide result valid this cycle.
- `imem_req` out 1: fetch request.
- `ir_load` out 1: load instruction register.
- `pc_write` out 1: PC ← PC+4.
- `branch` out 1: datapath takes the branch if the ALU zero flag is set.
- `mem_read` out 1: data-memory read request.
- `mem_write` out 1: data-memory write request.
- `mem_to_reg` out 1: write-back selects memory data.
- `alu_op` out 2: 00 add, 01 subtract/compare, 10 decode by funct.
- `alu_src` out 1: ALU operand B is the immediate.
- `reg_write` out 1: register-file write enable.
- `muldiv_start` out 1: one-cycle start pulse to the M unit.
- `trap` out 1: sticky halt.
- `trap_cause` out 2: 00 none, 01 illegal instruction, 10 fetch timeout, 11 data timeout.
- `instret` out `INSTRET_W`: retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, MULDIV, WB, TRAP.
- Reset value of every output is 0, including `instret` and `trap_cause`. The state resets to FETCH.
- FETCH: `imem_req`=1. On `imem_ready`, pulse `ir_load` and `pc_write`, then go to DECODE.
- DECODE: latch the control bundle from `opcode`/`funct7`. Next state:
  - legal opcode → EXEC;
  - M-type R instruction (funct7=0000001) → MULDIV;
  - illegal opcode → TRAP with cause 01.
- Control bundle per instruction class:
  - R: `reg_write`=1, `alu_op`=10, `alu_src`=0.
  - I-ALU: `reg_write`=1, `alu_op`=10, `alu_src`=1.
  - LW: `mem_read`, `mem_to_reg`, `reg_write` =1, `alu_op`=00, `alu_src`=1.
  - SW: `mem_write`=1, `alu_op`=00, `alu_src`=1.
  - BEQ: `branch`=1, `alu_op`=01, `alu_src`=0.
  - Any other opcode is illegal.
- Bundle outputs are gated by state:
  - `alu_op`/`alu_src` drive only in EXEC;
  - `mem_read`/`mem_write` drive only in MEM;
  - `reg_write`/`mem_to_reg` drive only in WB;
  - `branch` drives only in EXEC.
  - Everything else is 0.
- EXEC transitions: LW/SW → MEM; R/I → WB; BEQ → FETCH (retire).
- MEM: hold the request until `dmem_ready`. Then LW → WB; SW → FETCH (retire).
- MULDIV: `muldiv_start` pulses on the first cycle only. Wait for `muldiv_done`, then go to WB.
- WB: one cycle, then FETCH (retire).
- Retire: `instret` increments by 1 and wraps modulo 2^`INSTRET_W`.
- Timeout counter, width clog2(`MEM_TIMEOUT`+1):
  - cleared on entry to FETCH or MEM;
  - counts each cycle the relevant ready is low.
  - When it equals `MEM_TIMEOUT` with ready still low, go to TRAP (cause 10 from FETCH, 11 from MEM).
  - A ready seen on that same cycle wins, and no trap is taken.
- TRAP: all control outputs 0 and `trap`=1 until `rst`. Stimulus on any input is ignored.
- Reset asserted mid-instruction aborts immediately: state FETCH, outputs 0. The aborted instruction is not retired.

## Timing
- Minimum latency with ready/done asserted on the first cycle: BEQ 3 cycles, SW 4, R/I 4, LW 5, MUL/DIV 4 plus the M-unit latency.
- Outputs are a function of the registered state and the latched bundle only. There is no combinational input→output path except the FETCH `ir_load`/`pc_write`, which follow `imem_ready` in the same cycle.
- `instret` updates on the clock edge that leaves the retiring state.

## Configuration
- `RV32M_EN` defined: MULDIV state and `muldiv_start` are present. funct7=0000001 on the R opcode is legal.
- `RV32M_EN` undefined: MULDIV state is removed and `muldiv_start` is tied 0. Those encodings trap with cause 01.

## Structure
- `ctrl_pkg` holds the following, shared with the datapath:
  - the state enum;
  - opcode localparams;
  - `alu_op` encodings;
  - the `trap_cause` encodings;
  - the control-bundle struct.
- One sub-module, `main_decoder`: combinational opcode/funct7 → bundle plus an illegal flag, instantiated once.

## Test plan
- Reset then ADD (0110011, funct7 0) with ready high → FETCH,DECODE,EXEC,WB. `reg_write`=1 only in cycle 4. `instret`=1.
- LW with `dmem_ready` low for 3 cycles → `mem_read` held 4 cycles, `mem_to_reg`&`reg_write` in WB, total 8 cycles.
- BEQ → `branch`=1, `alu_op`=01 for exactly one cycle, back to FETCH after 3 cycles.
- Opcode 1111111 → TRAP, `trap_cause`=01, all strobes 0 for 20 further cycles until `rst`.
- `imem_ready` held low with `MEM_TIMEOUT`=15 → trap cause 10 after 16 FETCH cycles. `imem_ready` rising on cycle 16 → no trap.
- MUL with `RV32M_EN`: `muldiv_start` for 1 cycle, `muldiv_done` after 5 → WB. Without the macro, the same instruction → cause 01.
